// File: rtl/arm7_pkg.sv
// Shared definitions for the ARM7 banked register file.
// Holds the processor mode encodings, CPSR bit positions, and the helper
// functions that map a mode to its register bank and check it is legal.
package arm7_pkg;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  localparam int CPSR_N     = 31;
  localparam int CPSR_Z     = 30;
  localparam int CPSR_C     = 29;
  localparam int CPSR_V     = 28;
  localparam int CPSR_I     = 7;
  localparam int CPSR_F     = 6;
  localparam int CPSR_T     = 5;
  localparam int CPSR_M_MSB = 4;
  localparam int CPSR_M_LSB = 0;

  localparam int NUM_BANKS = 6;

  // USR and SYS share bank 0; each exception mode owns one bank.
  function automatic logic [2:0] mode_bank_idx(input logic [4:0] mode);
    logic [2:0] idx;
    idx = 3'd0;
    case (mode)
      MODE_FIQ: idx = 3'd1;
      MODE_IRQ: idx = 3'd2;
      MODE_SVC: idx = 3'd3;
      MODE_ABT: idx = 3'd4;
      MODE_UND: idx = 3'd5;
      default:  idx = 3'd0;
    endcase
    return idx;
  endfunction

  function automatic logic mode_legal(input logic [4:0] mode);
    logic ok;
    ok = 1'b0;
    case (mode)
      MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC,
      MODE_ABT, MODE_UND, MODE_SYS: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/arm7_mode_decode.sv
// Combinational decode of a 5-bit ARM7 mode field.
// Ports:
//   mode_i      - mode encoding to decode
//   bank_idx_o  - register bank index (0 for USR/SYS and illegal modes)
//   is_fiq_o    - mode is FIQ
//   has_spsr_o  - mode is a legal exception mode that owns an SPSR
//   legal_o     - encoding is one of the seven architected modes
module arm7_mode_decode
  import arm7_pkg::*;
(
  input  logic [4:0] mode_i,
  output logic [2:0] bank_idx_o,
  output logic       is_fiq_o,
  output logic       has_spsr_o,
  output logic       legal_o
);

  always_comb begin
    legal_o    = mode_legal(mode_i);
    bank_idx_o = mode_bank_idx(mode_i);
    is_fiq_o   = (mode_i == MODE_FIQ);
    has_spsr_o = legal_o && (bank_idx_o != 3'd0);
  end

endmodule

// File: rtl/arm7_banked_regfile.sv
// ARM7 register file: r0-r15, CPSR and five SPSRs with full mode banking,
// NUM_RD combinational read ports, MSR field writes, user-bank access and
// single-cycle exception entry / return. Owns PC, CPSR and the current mode.
// DATA_W must be at least 32 (PSRs are treated as four bytes).
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   rd_addr/rd_user/rd_data   - read ports (index, force user bank, value)
//   wr_en/wr_addr/wr_data     - register write port
//   wr_user                   - write the user bank regardless of mode
//   wr_restore_spsr           - with r15 write: CPSR <= current SPSR
//   psr_wr_en/psr_sel/psr_mask/psr_wr_data - MSR write
//   exc_req/exc_mode/exc_vector/exc_ret_addr - exception entry
//   pc_out/cpsr_out/spsr_out  - raw PC, CPSR, current SPSR (0 in USR/SYS)
//   mode_err                  - sticky illegal-mode flag
module arm7_banked_regfile
  import arm7_pkg::*;
#(
  parameter int                DATA_W         = 32,
  parameter int                NUM_RD         = 3,
  parameter logic [DATA_W-1:0] RESET_PC       = '0,
  parameter logic [4:0]        RESET_MODE     = 5'b10011,
  parameter int                PC_READ_OFFSET = 8,
  parameter bit                FIQ_BANK_EN    = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*4-1:0]      rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_RD-1:0]        rd_user,
  input  logic                     wr_en,
  input  logic [3:0]               wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_user,
  input  logic                     wr_restore_spsr,
  input  logic                     psr_wr_en,
  input  logic                     psr_sel,
  input  logic [3:0]               psr_mask,
  input  logic [DATA_W-1:0]        psr_wr_data,
  input  logic                     exc_req,
  input  logic [4:0]               exc_mode,
  input  logic [DATA_W-1:0]        exc_vector,
  input  logic [DATA_W-1:0]        exc_ret_addr,
  output logic [DATA_W-1:0]        pc_out,
  output logic [DATA_W-1:0]        cpsr_out,
  output logic [DATA_W-1:0]        spsr_out,
  output logic                     mode_err
);

  // I=1, F=1, T=0, mode=RESET_MODE
  localparam logic [DATA_W-1:0] CPSR_RST = DATA_W'({3'b110, RESET_MODE});

  logic [DATA_W-1:0] gpr_q  [13];         // r0-r12, user bank
  logic [DATA_W-1:0] fiq_q  [5];          // r8_fiq-r12_fiq
  logic [DATA_W-1:0] sp_q   [NUM_BANKS];  // r13 per bank
  logic [DATA_W-1:0] lr_q   [NUM_BANKS];  // r14 per bank
  logic [DATA_W-1:0] spsr_q [NUM_BANKS];  // entry 0 (USR/SYS) stays zero
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] cpsr_q, cpsr_d;
  logic              mode_err_q, mode_err_d;

  logic [4:0] cur_mode;
  logic [2:0] cur_bank;
  logic       cur_is_fiq, cur_has_spsr, cur_legal;
  logic [4:0] new_mode;
  logic [2:0] new_bank;
  logic       new_is_fiq, new_has_spsr, new_legal;

  assign cur_mode = cpsr_q[CPSR_M_MSB:CPSR_M_LSB];
  // The second decoder serves whichever request can change the mode this
  // cycle: exception entry wins, otherwise the MSR data mode field.
  assign new_mode = exc_req ? exc_mode : psr_wr_data[4:0];

  arm7_mode_decode u_cur_dec (
    .mode_i     (cur_mode),
    .bank_idx_o (cur_bank),
    .is_fiq_o   (cur_is_fiq),
    .has_spsr_o (cur_has_spsr),
    .legal_o    (cur_legal)
  );

  arm7_mode_decode u_new_dec (
    .mode_i     (new_mode),
    .bank_idx_o (new_bank),
    .is_fiq_o   (new_is_fiq),
    .has_spsr_o (new_has_spsr),
    .legal_o    (new_legal)
  );

  // Request arbitration. An MSR may share the cycle with a write to r0-r12
  // only; anything touching r13-r15 shares banking/PC state and wins alone.
  logic do_exc, do_wr, do_psr;
  assign do_exc = exc_req && new_legal;
  assign do_wr  = wr_en && !exc_req;
  assign do_psr = psr_wr_en && !exc_req && (!wr_en || (wr_addr <= 4'd12));

  logic [2:0] wr_bank;
  logic       wr_fiq_hi;
  assign wr_bank   = wr_user ? 3'd0 : cur_bank;
  assign wr_fiq_hi = FIQ_BANK_EN && !wr_user && cur_is_fiq;

  // MSR byte merge; an illegal mode in the c byte keeps the old mode bits.
  logic [3:0]        eff_mask;
  logic [DATA_W-1:0] psr_old, psr_new;
  logic              psr_mode_bad, spsr_we;

  always_comb begin
    eff_mask = (cur_mode == MODE_USR) ? {psr_mask[3], 3'b000} : psr_mask;
    psr_old  = psr_sel ? spsr_q[cur_bank] : cpsr_q;
    psr_new  = psr_old;
    for (int b = 0; b < 4; b++) begin
      if (eff_mask[b]) psr_new[b*8 +: 8] = psr_wr_data[b*8 +: 8];
    end
    psr_mode_bad = eff_mask[0] && !new_legal;
    if (psr_mode_bad) psr_new[4:0] = psr_old[4:0];
    spsr_we = do_psr && psr_sel && cur_has_spsr;
  end

  always_comb begin
    pc_d       = pc_q;
    cpsr_d     = cpsr_q;
    mode_err_d = mode_err_q;
    if (exc_req) begin
      if (new_legal) begin
        cpsr_d[CPSR_M_MSB:CPSR_M_LSB] = exc_mode;
        cpsr_d[CPSR_I]                = 1'b1;
        cpsr_d[CPSR_T]                = 1'b0;
        cpsr_d[CPSR_F]                = new_is_fiq;
        pc_d                          = exc_vector;
      end else begin
        mode_err_d = 1'b1;
      end
    end else begin
      if (wr_en && (wr_addr == 4'd15)) begin
        // Thumb keeps halfword alignment, ARM keeps word alignment.
        pc_d = cpsr_q[CPSR_T] ? {wr_data[DATA_W-1:1], 1'b0}
                              : {wr_data[DATA_W-1:2], 2'b00};
        if (wr_restore_spsr && cur_has_spsr && cur_legal) cpsr_d = spsr_q[cur_bank];
      end
      if (do_psr && !psr_sel) cpsr_d = psr_new;
      if (do_psr && psr_mode_bad && (!psr_sel || cur_has_spsr)) mode_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 13; i++) gpr_q[i] <= '0;
      for (int i = 0; i < 5; i++) fiq_q[i] <= '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
        sp_q[i]   <= '0;
        lr_q[i]   <= '0;
        spsr_q[i] <= '0;
      end
      pc_q       <= RESET_PC;
      cpsr_q     <= CPSR_RST;
      mode_err_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      cpsr_q     <= cpsr_d;
      mode_err_q <= mode_err_d;
      if (do_exc) begin
        lr_q[new_bank] <= exc_ret_addr;
        if (new_has_spsr) spsr_q[new_bank] <= cpsr_q;
      end
      if (do_wr) begin
        case (wr_addr)
          4'd15: ;
          4'd14: lr_q[wr_bank] <= wr_data;
          4'd13: sp_q[wr_bank] <= wr_data;
          default: begin
            if ((wr_addr >= 4'd8) && wr_fiq_hi) fiq_q[3'(wr_addr - 4'd8)] <= wr_data;
            else                                gpr_q[wr_addr]            <= wr_data;
          end
        endcase
      end
      if (spsr_we) spsr_q[cur_bank] <= psr_new;
    end
  end

  // Read ports: purely combinational from the current state, no bypass.
  always_comb begin
    logic [3:0] a;
    logic [2:0] bk;
    logic       fh;
    a  = '0;
    bk = '0;
    fh = 1'b0;
    rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a  = rd_addr[i*4 +: 4];
      bk = rd_user[i] ? 3'd0 : cur_bank;
      fh = FIQ_BANK_EN && !rd_user[i] && cur_is_fiq;
      case (a)
        4'd15:   rd_data[i*DATA_W +: DATA_W] = pc_q + DATA_W'(PC_READ_OFFSET);
        4'd14:   rd_data[i*DATA_W +: DATA_W] = lr_q[bk];
        4'd13:   rd_data[i*DATA_W +: DATA_W] = sp_q[bk];
        default: begin
          if ((a >= 4'd8) && fh) rd_data[i*DATA_W +: DATA_W] = fiq_q[3'(a - 4'd8)];
          else                   rd_data[i*DATA_W +: DATA_W] = gpr_q[a];
        end
      endcase
    end
  end

  assign pc_out   = pc_q;
  assign cpsr_out = cpsr_q;
  assign spsr_out = cur_has_spsr ? spsr_q[cur_bank] : '0;
  assign mode_err = mode_err_q;

endmodule

// File: tb/tb_arm7_banked_regfile.sv
// Scoreboard bench for arm7_banked_regfile: the stimulus process pushes
// hand-computed expectations, a monitor process compares them on negedge.
module tb_arm7_banked_regfile;

  localparam int DW = 32;
  localparam int NR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NR*4-1:0]   rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_user;
  logic              wr_en, wr_user, wr_restore_spsr;
  logic [3:0]        wr_addr;
  logic [DW-1:0]     wr_data;
  logic              psr_wr_en, psr_sel;
  logic [3:0]        psr_mask;
  logic [DW-1:0]     psr_wr_data;
  logic              exc_req;
  logic [4:0]        exc_mode;
  logic [DW-1:0]     exc_vector, exc_ret_addr;
  logic [DW-1:0]     pc_out, cpsr_out, spsr_out;
  logic              mode_err;

  arm7_banked_regfile #(
    .DATA_W(DW), .NUM_RD(NR), .RESET_PC(32'h0), .RESET_MODE(5'b10011),
    .PC_READ_OFFSET(8), .FIQ_BANK_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_user(rd_user),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_user(wr_user),
    .wr_restore_spsr(wr_restore_spsr),
    .psr_wr_en(psr_wr_en), .psr_sel(psr_sel), .psr_mask(psr_mask),
    .psr_wr_data(psr_wr_data),
    .exc_req(exc_req), .exc_mode(exc_mode), .exc_vector(exc_vector),
    .exc_ret_addr(exc_ret_addr),
    .pc_out(pc_out), .cpsr_out(cpsr_out), .spsr_out(spsr_out),
    .mode_err(mode_err)
  );

  // sel: 0..2 read port, 3 pc_out, 4 cpsr_out, 5 spsr_out, 6 mode_err
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic logic [31:0] dut_val(input int sel);
    logic [31:0] v;
    case (sel)
      0, 1, 2: v = rd_data[sel*DW +: DW];
      3:       v = pc_out;
      4:       v = cpsr_out;
      5:       v = spsr_out;
      default: v = {31'b0, mode_err};
    endcase
    return v;
  endfunction

  // Monitor: everything queued since the last edge is checked at negedge.
  initial begin : monitor
    exp_t        e;
    logic [31:0] got;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        got = dut_val(e.sel);
        n_chk++;
        if (got !== e.exp) begin
          n_err++;
          $display("FAIL %s: got %08h expected %08h", e.name, got, e.exp);
        end
      end
    end
  end

  task automatic push_exp(input string n, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.sel  = sel;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic rd(input int p, input logic [3:0] a, input logic u,
                    input string n, input logic [31:0] v);
    rd_addr[p*4 +: 4] = a;
    rd_user[p]        = u;
    push_exp(n, p, v);
  endtask

  task automatic clr();
    wr_en = 0; wr_user = 0; wr_restore_spsr = 0; wr_addr = 0; wr_data = 0;
    psr_wr_en = 0; psr_sel = 0; psr_mask = 0; psr_wr_data = 0;
    exc_req = 0; exc_mode = 0; exc_vector = 0; exc_ret_addr = 0;
    rd_addr = '0; rd_user = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_wr(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
  endtask

  task automatic do_msr(input logic s, input logic [3:0] m, input logic [31:0] d);
    psr_wr_en = 1; psr_sel = s; psr_mask = m; psr_wr_data = d;
  endtask

  task automatic do_exc(input logic [4:0] m, input logic [31:0] v, input logic [31:0] r);
    exc_req = 1; exc_mode = m; exc_vector = v; exc_ret_addr = r;
  endtask

  initial begin : stim
    int guard;
    clr();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    rd(0, 4'd15, 0, "reset_r15", 32'h8);
    rd(1, 4'd0, 0, "reset_r0", 32'h0);
    push_exp("reset_pc", 3, 32'h0);
    push_exp("reset_cpsr", 4, 32'h000000D3);
    push_exp("reset_spsr", 5, 32'h0);
    push_exp("reset_merr", 6, 32'h0);
    settle();

    // SVC r13
    do_wr(4'd13, 32'hAAAA0000); step();
    rd(0, 4'd13, 0, "svc_r13", 32'hAAAA0000);
    settle();

    // MSR to USR, then flags
    do_msr(0, 4'b0001, 32'h00000010); step();
    push_exp("msr_usr_cpsr", 4, 32'h00000010);
    push_exp("usr_spsr", 5, 32'h0);
    rd(0, 4'd13, 0, "usr_r13", 32'h0);
    settle();
    do_msr(0, 4'b1000, 32'h60000000); step();
    push_exp("usr_flags_cpsr", 4, 32'h60000010);
    settle();

    // FIQ entry from USR
    do_exc(5'b10001, 32'h1C, 32'h104); step();
    push_exp("fiq_pc", 3, 32'h1C);
    push_exp("fiq_cpsr", 4, 32'h600000D1);
    push_exp("fiq_spsr", 5, 32'h60000010);
    rd(0, 4'd14, 0, "fiq_lr", 32'h104);
    rd(1, 4'd15, 0, "fiq_r15", 32'h24);
    settle();

    do_wr(4'd8, 32'h5); step();
    rd(0, 4'd8, 0, "fiq_r8", 32'h5);
    rd(1, 4'd8, 1, "fiq_r8_user", 32'h0);
    rd(2, 4'd13, 1, "fiq_r13_user", 32'h0);
    settle();

    // Return: r15 write with SPSR restore
    do_wr(4'd15, 32'h107); wr_restore_spsr = 1; step();
    push_exp("ret_pc", 3, 32'h104);
    push_exp("ret_cpsr", 4, 32'h60000010);
    push_exp("ret_spsr", 5, 32'h0);
    rd(0, 4'd8, 0, "ret_r8", 32'h0);
    settle();

    // In USR only the f byte may change
    do_msr(0, 4'b1111, 32'h600000DF); step();
    push_exp("usr_msr_fonly", 4, 32'h60000010);
    push_exp("usr_msr_merr", 6, 32'h0);
    settle();

    // SVC entry recovers the banked r13
    do_exc(5'b10011, 32'h08, 32'h200); step();
    push_exp("svc_cpsr", 4, 32'h60000093);
    push_exp("svc_spsr", 5, 32'h60000010);
    rd(0, 4'd13, 0, "svc_r13_back", 32'hAAAA0000);
    rd(1, 4'd14, 0, "svc_lr", 32'h200);
    rd(2, 4'd13, 1, "svc_r13_user", 32'h0);
    settle();

    // Illegal mode via MSR
    do_msr(0, 4'b0001, 32'h00000015); step();
    push_exp("bad_msr_cpsr", 4, 32'h60000013);
    push_exp("bad_msr_merr", 6, 32'h1);
    settle();

    // Illegal exception mode is ignored
    do_exc(5'b10101, 32'h44, 32'h55); step();
    push_exp("bad_exc_pc", 3, 32'h08);
    push_exp("bad_exc_cpsr", 4, 32'h60000013);
    push_exp("bad_exc_merr", 6, 32'h1);
    settle();

    // exc_req beats wr_en r15
    do_exc(5'b10010, 32'h18, 32'h300); do_wr(4'd15, 32'h40); step();
    push_exp("coll_pc", 3, 32'h18);
    push_exp("coll_cpsr", 4, 32'h60000092);
    push_exp("coll_spsr", 5, 32'h60000013);
    rd(0, 4'd14, 0, "coll_lr_irq", 32'h300);
    settle();

    // r0 write and MSR in the same cycle both proceed
    do_wr(4'd0, 32'h1234); do_msr(0, 4'b0001, 32'h0000001F); step();
    rd(0, 4'd0, 0, "dual_r0", 32'h1234);
    push_exp("dual_cpsr", 4, 32'h6000001F);
    push_exp("sys_spsr", 5, 32'h0);
    push_exp("merr_sticky", 6, 32'h1);
    settle();

    // r13 write drops a colliding MSR
    do_wr(4'd13, 32'h77); do_msr(0, 4'b1000, 32'hF0000000); step();
    push_exp("r13_msr_drop", 4, 32'h6000001F);
    rd(0, 4'd13, 0, "sys_r13", 32'h77);
    rd(1, 4'd13, 1, "sys_r13_user", 32'h77);
    settle();

    // Thumb-state r15 write keeps bit 1
    do_msr(0, 4'b0001, 32'h0000003F); step();
    push_exp("thumb_cpsr", 4, 32'h6000003F);
    settle();
    do_wr(4'd15, 32'h107); step();
    push_exp("thumb_pc", 3, 32'h106);
    rd(0, 4'd15, 0, "thumb_r15", 32'h10E);
    settle();

    // Reset clears mode_err and restores state
    rst = 1; do_wr(4'd0, 32'hDEAD); step(); rst = 0;
    push_exp("rst2_pc", 3, 32'h0);
    push_exp("rst2_cpsr", 4, 32'h000000D3);
    push_exp("rst2_merr", 6, 32'h0);
    rd(0, 4'd0, 0, "rst2_r0", 32'h0);
    settle();

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/arm7_banked_regfile.md
Name: arm7_banked_regfile

Overview:
- Parametrised ARM7 register file: r0–r15, CPSR and five SPSRs, with full mode banking and NUM_RD combinational read ports.
- Adds behaviour the first-generation file lacks: reset, readable state, CPSR field writes, user-bank access, and single-cycle exception entry and return.
- Sits between the decode/execute stage and the writeback bus; it is the sole owner of PC, CPSR and the current mode.

Parameters:
- DATA_W, 32, register width.
- NUM_RD, 3, number of read ports.
- RESET_PC, 0, PC value after reset.
- RESET_MODE, 5'b10011, CPSR[4:0] after reset (SVC).
- PC_READ_OFFSET, 8, value added to the PC on an r15 read.
- FIQ_BANK_EN, 1, when 1, r8–r12 are banked in FIQ mode.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rd_addr  in  NUM_RD*4  read register indices, one per port
- rd_data  out  NUM_RD*DATA_W  read values, combinational from current state
- rd_user  in  NUM_RD  per port: read the user bank regardless of mode
- wr_en  in  1  register write strobe
- wr_addr  in  4  register write index
- wr_data  in  DATA_W  register write value
- wr_user  in  1  write the user bank regardless of mode (LDM^)
- wr_restore_spsr  in  1  with wr_addr==15: CPSR <= current SPSR
- psr_wr_en  in  1  MSR strobe
- psr_sel  in  1  MSR target: 0 = CPSR, 1 = current SPSR
- psr_mask  in  4  MSR field mask {f,s,x,c}; bit i writes byte i
- psr_wr_data  in  DATA_W  MSR value
- exc_req  in  1  exception entry strobe
- exc_mode  in  5  target mode encoding
- exc_vector  in  DATA_W  new PC
- exc_ret_addr  in  DATA_W  value for the target mode's LR
- pc_out  out  DATA_W  raw PC register
- cpsr_out  out  DATA_W  CPSR
- spsr_out  out  DATA_W  SPSR of the current mode; 0 in USR/SYS
- mode_err  out  1  sticky flag: an illegal mode write was attempted

Behaviour:
- Reset, synchronous on posedge clk while rst=1:
  - every GPR and banked register <= 0, every SPSR <= 0;
  - PC <= RESET_PC;
  - CPSR <= {24'b0, I=1, F=1, T=0, RESET_MODE};
  - mode_err <= 0.
- Reset overrides every other input in the same cycle.
- Mode encodings:
  - USR 10000, FIQ 10001, IRQ 10010, SVC 10011, ABT 10111, UND 11011, SYS 11111.
  - Bank index: USR/SYS=0, FIQ=1, IRQ=2, SVC=3, ABT=4, UND=5.
- Register mapping:
  - r13 and r14 are banked per bank index.
  - r8–r12 are banked only for FIQ, and only when FIQ_BANK_EN=1.
  - rd_user / wr_user force bank index 0.
- Reads:
  - Zero latency.
  - r15 returns PC + PC_READ_OFFSET, truncated to DATA_W.
  - Writes become visible the cycle after the clock edge; there is no bypass.
- Register write:
  - Writes to r15 store wr_data with bits [1:0] cleared, or only bit [0] cleared when CPSR.T=1.
  - wr_restore_spsr applies only when wr_addr==15. CPSR <= SPSR[current bank] in the same edge.
  - In USR/SYS, wr_restore_spsr is ignored.
- MSR:
  - Byte i of the selected PSR <= psr_wr_data byte i, for each set psr_mask[i].
  - In USR mode only the f byte is writable.
  - An SPSR target in USR/SYS is a no-op.
  - If the written c byte carries an illegal mode: CPSR[4:0] is left unchanged, the other written bytes still apply, and mode_err <= 1.
- Exception entry, single cycle on exc_req with a legal exc_mode:
  - SPSR[target] <= old CPSR;
  - LR[target] <= exc_ret_addr;
  - CPSR[4:0] <= exc_mode, I <= 1, T <= 0, F <= 1 iff exc_mode is FIQ;
  - PC <= exc_vector.
- exc_req with an illegal exc_mode is ignored and sets mode_err <= 1.
- Priority in one cycle: rst > exc_req > wr_en > psr_wr_en.
  - A lower-priority request colliding with a higher one is dropped entirely.
  - Exception: a wr_en to r0–r12 proceeds alongside psr_wr_en. The register write uses the pre-edge mode.
- mode_err clears only on reset.

Decomposition:
- Package arm7_pkg holds:
  - the mode localparams (MODE_USR…MODE_SYS);
  - CPSR bit positions (N, Z, C, V, I, F, T, M);
  - the bank-index function;
  - the mode-legal function.
- Sub-module arm7_mode_decode: combinational, 5-bit mode in, outputs {bank_idx[2:0], is_fiq, has_spsr, legal}.
  - Instantiated once for the current mode and once for exc_mode / the MSR data mode field.

Test Plan:
- Reset, then read r15 and cpsr_out → rd_data = 0x8, cpsr_out = 0x000000D3, spsr_out = 0.
- In SVC, write r13 = 0xAAAA0000; MSR CPSR c = 0x10 (USR); read r13 → 0; read r13 with rd_user=0 back in SVC mode via exception → 0xAAAA0000.
- exc_req with mode=FIQ, vector=0x1C, ret=0x104 from USR with CPSR=0x60000010 → PC = 0x1C, CPSR = 0x600000D1, SPSR_fiq = 0x60000010, LR_fiq = 0x104. Then write r8 = 5; in USR, r8 = 0.
- In FIQ, wr_en r15 = 0x107 with wr_restore_spsr → PC = 0x104, CPSR = 0x60000010, reads of r8 return the user value.
- MSR CPSR mask=0001 with data 0x00000015 (illegal) → mode unchanged, mode_err = 1 and stays 1 until rst.
- Same cycle exc_req + wr_en r15 = 0x40 → PC = exc_vector; the r15 write is dropped.
